uart_send_queue: RTL and testbench

Buffers outgoing UART bytes between the byte producers (core io_send, boot loader) and the UART transmitter, so the core is not stalled for a full character time per byte. Core bytes enter a FIFO. Boot-loader bytes use a one-entry bypass register that has priority. The block owns the tx_start/tx_busy handshake with the transmitter and presents a busy flag back to the core.

---
 rtl/uart_send_queue_pkg.sv | 16 +
 rtl/uart_send_queue_if.sv | 40 ++++
 rtl/uart_send_queue_byte_fifo.sv | 55 +++++
 rtl/uart_send_queue.sv | 118 +++++++++++
 tb/tb_uart_send_queue.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_send_queue_pkg.sv
// Shared types for the UART send queue.
// Byte/word aliases and the transmit FSM states.
package uart_send_queue_pkg;

  typedef logic [7:0]  w8;
  typedef logic [31:0] w32;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    WAIT
  } tx_state_t;

  localparam int unsigned DEF_DEPTH = 16;

endpackage

// File: rtl/uart_send_queue_if.sv
// Producer and transmitter signals of the send queue.
// master: core, boot loader and UartTx; slave: the queue.
interface uart_send_queue_if;
  import uart_send_queue_pkg::*;

  logic core_en;
  w32   core_data;
  logic core_busy;
  logic boot_en;
  w8    boot_data;
  logic boot_busy;
  logic tx_busy;
  logic tx_start;
  w8    sdata;

  modport master (
    output core_en,
    output core_data,
    output boot_en,
    output boot_data,
    output tx_busy,
    input  core_busy,
    input  boot_busy,
    input  tx_start,
    input  sdata
  );

  modport slave (
    input  core_en,
    input  core_data,
    input  boot_en,
    input  boot_data,
    input  tx_busy,
    output core_busy,
    output boot_busy,
    output tx_start,
    output sdata
  );

endinterface

// File: rtl/uart_send_queue_byte_fifo.sv
// Circular byte FIFO with registered count.
// Pushes when full and pops when empty are ignored.
module uart_send_queue_byte_fifo
  import uart_send_queue_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  w8              push_data,
  input  logic           pop,
  output w8              pop_data,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  w8                mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == (PTR_W+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_send_queue.sv
// UART send queue: core FIFO plus boot bypass feeding UartTx.
// Owns the tx_start/tx_busy handshake and the sticky overflow.
module uart_send_queue
  import uart_send_queue_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  uart_send_queue_if.slave  bus,
  output logic              overflow,
  output logic [PTR_W:0]    level
);

  tx_state_t state;
  tx_state_t state_nx;

  logic byp_v;
  w8    byp_q;
  logic byp_clr;

  logic fifo_full;
  logic fifo_empty;
  w8    fifo_q;
  logic pop;

  logic tx_start_q;
  logic start_nx;
  w8    sdata_q;
  w8    sdata_nx;

  logic unused_hi;
  assign unused_hi = ^bus.core_data[31:8];

  uart_send_queue_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bus.core_en),
    .push_data (bus.core_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (level)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // GUARD covers the cycle before UartTx raises busy.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    byp_clr  = 1'b0;
    start_nx = 1'b0;
    sdata_nx = sdata_q;
    unique case (state)
      IDLE: begin
        if (byp_v) begin
          sdata_nx = byp_q;
          byp_clr  = 1'b1;
          start_nx = 1'b1;
          state_nx = GUARD;
        end else if (!fifo_empty) begin
          sdata_nx = fifo_q;
          pop      = 1'b1;
          start_nx = 1'b1;
          state_nx = GUARD;
        end
      end
      GUARD: state_nx = WAIT;
      WAIT:  if (!bus.tx_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_start_q <= 1'b0;
      sdata_q    <= '0;
    end else begin
      tx_start_q <= start_nx;
      sdata_q    <= sdata_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byp_v <= 1'b0;
      byp_q <= '0;
    end else if (byp_clr) begin
      byp_v <= 1'b0;
    end else if (bus.boot_en && !byp_v) begin
      byp_v <= 1'b1;
      byp_q <= bus.boot_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if ((bus.core_en && fifo_full) ||
                 (bus.boot_en && byp_v)) begin
      overflow <= 1'b1;
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.sdata     = sdata_q;
  assign bus.core_busy = fifo_full;
  assign bus.boot_busy = byp_v;

endmodule

// File: tb/tb_uart_send_queue.sv
// Scoreboard bench for uart_send_queue.
// Queue-level reference model plus a simple UartTx busy model.
module tb_uart_send_queue;
  import uart_send_queue_pkg::*;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       overflow;
  logic [4:0] level;

  uart_send_queue_if bus();

  uart_send_queue #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned fifo_m[$];
  bit           byp_v_m = 1'b0;
  byte unsigned byp_m   = 8'h00;
  bit           ovf_m   = 1'b0;
  byte unsigned sdata_m = 8'h00;
  int           n_sent  = 0;

  int char_len = 10;
  bit hold     = 1'b0;
  int busy_cnt = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // UartTx model: busy for char_len cycles starting the cycle after start.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus.tx_busy = hold || (busy_cnt > 0);
      if (bus.tx_start)
        busy_cnt = char_len;
      else if (!hold && busy_cnt > 0)
        busy_cnt--;
    end
  end

  // Monitor and reference model.
  initial begin
    bit           r, ce, be, pre_byp;
    byte unsigned cd, bd;
    int           pre_size;
    forever begin
      @(posedge clock);
      r        = reset;
      ce       = bus.core_en;
      cd       = bus.core_data[7:0];
      be       = bus.boot_en;
      bd       = bus.boot_data;
      pre_size = fifo_m.size();
      pre_byp  = byp_v_m;
      #1;
      if (r) begin
        fifo_m.delete();
        byp_v_m = 1'b0;
        ovf_m   = 1'b0;
        sdata_m = 8'h00;
        check("rst_tx_start", bus.tx_start, 0);
      end else begin
        if (bus.tx_start) begin
          if (pre_byp) begin
            sdata_m = byp_m;
            byp_v_m = 1'b0;
            check("tx_byte", bus.sdata, sdata_m);
          end else if (fifo_m.size() > 0) begin
            sdata_m = fifo_m.pop_front();
            check("tx_byte", bus.sdata, sdata_m);
          end else begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_start: sdata %0h with nothing queued at %0t",
                     bus.sdata, $time);
          end
          n_sent++;
        end
        if (ce) begin
          if (pre_size < DEPTH) fifo_m.push_back(cd);
          else                  ovf_m = 1'b1;
        end
        if (be) begin
          if (!pre_byp) begin
            byp_v_m = 1'b1;
            byp_m   = bd;
          end else begin
            ovf_m = 1'b1;
          end
        end
      end
      check("level",     level,         fifo_m.size());
      check("core_busy", bus.core_busy, fifo_m.size() == DEPTH);
      check("boot_busy", bus.boot_busy, byp_v_m);
      check("overflow",  overflow,      ovf_m);
      check("sdata",     bus.sdata,     sdata_m);
    end
  end

  task automatic idle();
    @(negedge clock);
    bus.core_en = 1'b0;
    bus.boot_en = 1'b0;
  endtask

  task automatic push_core(logic [7:0] b);
    logic [31:0] w;
    w = $urandom;
    @(negedge clock);
    bus.core_en   = 1'b1;
    bus.core_data = {w[31:8], b};
    bus.boot_en   = 1'b0;
  endtask

  task automatic do_reset(int n);
    idle();
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(int limit);
    int k;
    idle();
    k = 0;
    while ((fifo_m.size() != 0 || byp_v_m || bus.tx_busy || busy_cnt != 0)
           && k < limit) begin
      @(negedge clock);
      k++;
    end
    n_tests++;
    if (k >= limit) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes left after %0d cycles",
               fifo_m.size(), k);
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int s0;
    bus.core_en   = 1'b0;
    bus.core_data = '0;
    bus.boot_en   = 1'b0;
    bus.boot_data = '0;

    // Three core bytes in order
    do_reset(3);
    s0 = n_sent;
    char_len = 10;
    push_core(8'h41);
    push_core(8'h42);
    push_core(8'h43);
    drain(200);
    check("p1_sent", n_sent - s0, 3);

    // Fill to full behind a held transmitter, then overflow
    s0 = n_sent;
    @(negedge clock);
    hold = 1'b1;
    push_core(8'hA5);
    idle();
    repeat (3) @(negedge clock);
    for (int i = 0; i < 16; i++) push_core(8'(i));
    idle();
    check("full_level", level, 16);
    check("full_busy", bus.core_busy, 1);
    check("full_ovf0", overflow, 0);
    push_core(8'hFF);
    idle();
    check("full_ovf1", overflow, 1);
    check("full_level2", level, 16);
    hold = 1'b0;
    drain(600);
    check("p2_sent", n_sent - s0, 17);

    // Boot and core in the same cycle, then a dropped boot byte
    do_reset(2);
    s0 = n_sent;
    @(negedge clock);
    bus.core_en   = 1'b1;
    bus.core_data = 32'hDEAD_BE11;
    bus.boot_en   = 1'b1;
    bus.boot_data = 8'h22;
    @(negedge clock);
    bus.core_en   = 1'b0;
    bus.boot_en   = 1'b1;
    bus.boot_data = 8'h33;
    idle();
    check("boot_ovf", overflow, 1);
    drain(200);
    check("p3_sent", n_sent - s0, 2);

    // Random traffic with short characters; pointers wrap many times
    do_reset(2);
    s0 = n_sent;
    char_len = 2;
    for (int i = 0; i < 500; i++) begin
      logic [31:0] w;
      w = $urandom;
      @(negedge clock);
      bus.core_en   = ($urandom_range(99) < 22);
      bus.core_data = w;
      bus.boot_en   = ($urandom_range(99) < 3);
      bus.boot_data = 8'($urandom);
    end
    drain(800);
    n_tests++;
    if (n_sent - s0 < 40) begin
      n_fail++;
      $display("FAIL rand_volume: sent %0d, need at least 40", n_sent - s0);
    end

    // Reset while waiting with four bytes queued
    do_reset(2);
    char_len = 10;
    @(negedge clock);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) push_core(8'h51 + 8'(i));
    idle();
    repeat (2) @(negedge clock);
    check("pre_rst_level", level, 4);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_level",     level,         0);
    check("rst_start",     bus.tx_start,  0);
    check("rst_sdata",     bus.sdata,     0);
    check("rst_core_busy", bus.core_busy, 0);
    check("rst_boot_busy", bus.boot_busy, 0);
    check("rst_overflow",  overflow,      0);
    s0 = n_sent;
    hold = 1'b0;
    repeat (40) @(negedge clock);
    check("rst_quiet", n_sent - s0, 0);
    push_core(8'h77);
    drain(200);
    check("post_rst_sent", n_sent - s0, 1);

    check("final_fifo_empty", fifo_m.size(), 0);
    check("final_byp_empty", byp_v_m, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
